// File: rtl/instr_trace_pkg.sv
// rtl/instr_trace_pkg.sv - Brainfuck ASCII op constants and op-strobe encoder helper
// Contents:
//   CHAR_*           ASCII codes for the eight ops
//   ERR_CHAR         byte emitted for illegal strobe combinations
//   NOP_CHAR_DEFAULT default byte for nop cycles (INSTR_TRACE_NOP_EN builds)
//   encode_op()      one-hot strobe vector -> ASCII
//                    bit order: {loop_end, loop_start, in_d, out_d, dec_d, inc_d, dec_dp, inc_dp}
package instr_trace_pkg;

    localparam logic [7:0] CHAR_INC_DP     = 8'h3E;
    localparam logic [7:0] CHAR_DEC_DP     = 8'h3C;
    localparam logic [7:0] CHAR_INC_D      = 8'h2B;
    localparam logic [7:0] CHAR_DEC_D      = 8'h2D;
    localparam logic [7:0] CHAR_OUT_D      = 8'h2E;
    localparam logic [7:0] CHAR_IN_D       = 8'h2C;
    localparam logic [7:0] CHAR_LOOP_START = 8'h5B;
    localparam logic [7:0] CHAR_LOOP_END   = 8'h5D;
    localparam logic [7:0] ERR_CHAR        = 8'h3F;
    localparam logic [7:0] NOP_CHAR_DEFAULT = 8'h20;

    // Any vector that is not exactly one-hot maps to ERR_CHAR.
    function automatic logic [7:0] encode_op(input logic [7:0] strobes);
        logic [7:0] ch;
        case (strobes)
            8'b0000_0001: ch = CHAR_INC_DP;
            8'b0000_0010: ch = CHAR_DEC_DP;
            8'b0000_0100: ch = CHAR_INC_D;
            8'b0000_1000: ch = CHAR_DEC_D;
            8'b0001_0000: ch = CHAR_OUT_D;
            8'b0010_0000: ch = CHAR_IN_D;
            8'b0100_0000: ch = CHAR_LOOP_START;
            8'b1000_0000: ch = CHAR_LOOP_END;
            default:      ch = ERR_CHAR;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/instr_trace_fifo.sv
// rtl/instr_trace_fifo.sv - DEPTH-entry synchronous byte FIFO
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request; accepted when not full or popping this cycle
//   pop                 read request; accepted when not empty
//   full, empty, level  occupancy status (registered count)
//   head                oldest entry, 0x00 while empty
module instr_trace_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [7:0]    head
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    assign rd_en = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);

    // Masking with empty keeps head at 0x00 after reset without clearing storage.
    assign head = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_trace_encoder.sv
// rtl/instr_trace_encoder.sv - Brainfuck decode strobes to ASCII trace byte stream
// Optional feature macro: INSTR_TRACE_NOP_EN (valid nop cycles push NOP_CHAR)
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid                         one executed instruction this cycle
//   inc_dp .. loop_end, nop          one-hot op strobes / no-op flag
//   out_valid, out_ready, out_byte   byte stream to the consumer
//   level                            FIFO occupancy 0..DEPTH
//   overflow, illegal, clr_flags     sticky error flags and their clear
module instr_trace_encoder
    import instr_trace_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] NOP_CHAR = NOP_CHAR_DEFAULT,
    localparam int        LW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          inc_dp,
    input  logic          dec_dp,
    input  logic          inc_d,
    input  logic          dec_d,
    input  logic          out_d,
    input  logic          in_d,
    input  logic          loop_start,
    input  logic          loop_end,
    input  logic          nop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_byte,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          illegal,
    input  logic          clr_flags
);

    logic [7:0] strobes;
    logic       one_hot;
    logic       push;
    logic [7:0] push_data;
    logic       illegal_evt;
    logic       overflow_evt;
    logic       pop;
    logic       full;
    logic       empty;

    assign strobes = {loop_end, loop_start, in_d, out_d, dec_d, inc_d, dec_dp, inc_dp};
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign one_hot = (strobes & (strobes - 8'd1)) == 8'd0;

    always_comb begin
        push        = 1'b0;
        push_data   = ERR_CHAR;
        illegal_evt = 1'b0;
        if (in_valid) begin
            if (strobes == 8'd0) begin
                // No strobe at all is a nop, whether or not nop is raised.
                push_data = NOP_CHAR;
`ifdef INSTR_TRACE_NOP_EN
                push      = 1'b1;
`endif
            end else if (nop || !one_hot) begin
                push        = 1'b1;
                push_data   = ERR_CHAR;
                illegal_evt = 1'b1;
            end else begin
                push      = 1'b1;
                push_data = encode_op(strobes);
            end
        end
    end

    assign out_valid    = !empty;
    assign pop          = out_valid && out_ready;
    assign overflow_evt = push && full && !pop;

    instr_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .head      (out_byte)
    );

    // A new event wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (overflow_evt)   overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (illegal_evt)    illegal  <= 1'b1;
            else if (clr_flags) illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_trace_encoder.sv
// tb/tb_instr_trace_encoder.sv - self-checking bench for instr_trace_encoder
module tb_instr_trace_encoder;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    s_in = 8'd0;
    logic          nop = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_flags = 1'b0;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic [LW-1:0] level;
    logic          overflow;
    logic          illegal;

    always #5 clk = ~clk;

    instr_trace_encoder #(.DEPTH(DEPTH), .NOP_CHAR(8'h20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .inc_dp     (s_in[0]),
        .dec_dp     (s_in[1]),
        .inc_d      (s_in[2]),
        .dec_d      (s_in[3]),
        .out_d      (s_in[4]),
        .in_d       (s_in[5]),
        .loop_start (s_in[6]),
        .loop_end   (s_in[7]),
        .nop        (nop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .level      (level),
        .overflow   (overflow),
        .illegal    (illegal),
        .clr_flags  (clr_flags)
    );

    // Reference model: a queue of bytes plus two flag bits.
    byte unsigned chars [8] = '{8'h3E, 8'h3C, 8'h2B, 8'h2D, 8'h2E, 8'h2C, 8'h5B, 8'h5D};
    byte unsigned mq [$];
    bit           m_ovf = 0;
    bit           m_ill = 0;
`ifdef INSTR_TRACE_NOP_EN
    localparam bit NOP_EN = 1'b1;
`else
    localparam bit NOP_EN = 1'b0;
`endif

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input bit v, input logic [7:0] s, input bit n,
                              input bit r, input bit c);
        int          ones = 0;
        int          idx = 0;
        bit          do_push = 0;
        bit          ill_evt = 0;
        bit          ovf_evt = 0;
        bit          do_pop;
        byte unsigned b = 0;
        for (int i = 0; i < 8; i++) if (s[i]) begin ones++; idx = i; end
        if (v) begin
            if (ones == 0) begin do_push = NOP_EN; b = 8'h20; end
            else if (ones > 1 || n) begin do_push = 1; b = 8'h3F; ill_evt = 1; end
            else begin do_push = 1; b = chars[idx]; end
        end
        do_pop = (mq.size() > 0) && r;
        if (do_push && mq.size() == DEPTH && !do_pop) begin
            do_push = 0;
            ovf_evt = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(b);
        m_ovf = ovf_evt ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_ill = ill_evt ? 1'b1 : (c ? 1'b0 : m_ill);
    endtask

    task automatic check_model();
        check("m_valid", out_valid, mq.size() > 0);
        check("m_byte", out_byte, mq.size() > 0 ? mq[0] : 8'h00);
        check("m_level", level, mq.size());
        check("m_overflow", overflow, m_ovf);
        check("m_illegal", illegal, m_ill);
    endtask

    // Apply one cycle of inputs, clock it, compare with the model just after the edge.
    task automatic drive(input bit v, input logic [7:0] s, input bit n,
                         input bit r, input bit c);
        in_valid = v; s_in = s; nop = n; out_ready = r; clr_flags = c;
        model_step(v, s, n, r, c);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         v;
        logic [7:0] s;
        bit         n;
        bit         r;
        bit         c;
        bit         ev;
        logic [7:0] eb;
        int         el;
        bit         eo;
        bit         ei;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit v, logic [7:0] s, bit n, bit r, bit c,
                                bit ev, logic [7:0] eb, int el, bit eo, bit ei);
        vec_t t;
        t.v = v; t.s = s; t.n = n; t.r = r; t.c = c;
        t.ev = ev; t.eb = eb; t.el = el; t.eo = eo; t.ei = ei;
        return t;
    endfunction

    byte unsigned exp_bytes [$];
    logic [7:0]   st;
    int           k;

    initial begin
        // Directed stream: + + > . [ ] with out_ready high
        tbl.push_back(mk(1, 8'h04, 0, 1, 0, 1, 8'h2B, 1, 0, 0));
        tbl.push_back(mk(1, 8'h04, 0, 1, 0, 1, 8'h2B, 1, 0, 0));
        tbl.push_back(mk(1, 8'h01, 0, 1, 0, 1, 8'h3E, 1, 0, 0));
        tbl.push_back(mk(1, 8'h10, 0, 1, 0, 1, 8'h2E, 1, 0, 0));
        tbl.push_back(mk(1, 8'h40, 0, 1, 0, 1, 8'h5B, 1, 0, 0));
        tbl.push_back(mk(1, 8'h80, 0, 1, 0, 1, 8'h5D, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0));
        // Illegal combinations, clear, and set-beats-clear
        tbl.push_back(mk(1, 8'h0C, 0, 0, 0, 1, 8'h3F, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h3F, 1, 0, 0));
        tbl.push_back(mk(1, 8'h0C, 0, 1, 1, 1, 8'h3F, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h3F, 1, 0, 0));
        tbl.push_back(mk(1, 8'h01, 1, 1, 0, 1, 8'h3F, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0));
        // Nop stream: three nop cycles plus one all-zero valid cycle, then drain
        k = NOP_EN ? 1 : 0;
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk(1, 8'h00, 1, 0, 0, k == 1, k ? 8'h20 : 8'h00, k * i, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, k == 1, k ? 8'h20 : 8'h00, k * 4, 0, 0));
        for (int i = 3; i >= 0; i--)
            tbl.push_back(mk(0, 8'h00, 0, 1, 0, (k * i) > 0, (k * i) > 0 ? 8'h20 : 8'h00,
                             k * i, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_byte", out_byte, 8'h00);
        check("rst_flags", {overflow, illegal}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].n, tbl[i].r, tbl[i].c);
            check($sformatf("t%0d_valid", i), out_valid, tbl[i].ev);
            check($sformatf("t%0d_byte", i), out_byte, tbl[i].eb);
            check($sformatf("t%0d_level", i), level, tbl[i].el);
            check($sformatf("t%0d_ovf", i), overflow, tbl[i].eo);
            check($sformatf("t%0d_ill", i), illegal, tbl[i].ei);
        end

        // Overflow: nine pushes into an eight-deep FIFO with no consumer
        exp_bytes.delete();
        for (int i = 0; i < 9; i++) begin
            k = $urandom_range(0, 7);
            st = 8'(1) << k;
            if (i < 8) exp_bytes.push_back(chars[k]);
            drive(1, st, 0, 0, 0);
        end
        check("ovf_level", level, 8);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), out_byte, exp_bytes[i]);
            drive(0, 8'h00, 0, 1, 0);
        end
        check("ovf_empty", out_valid, 0);
        drive(0, 8'h00, 0, 0, 1);
        check("ovf_clr", overflow, 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) drive(1, 8'h02, 0, 0, 0);
        drive(1, 8'h80, 0, 1, 0);
        check("fullpp_level", level, 8);
        check("fullpp_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("fullpp_last", out_byte, 8'h5D);
            else check($sformatf("fullpp_b%0d", i), out_byte, 8'h3C);
            drive(0, 8'h00, 0, 1, 0);
        end

        // Asynchronous reset with five entries queued
        for (int i = 0; i < 5; i++) drive(1, 8'h20, 0, 0, 0);
        check("pre_rst_level", level, 5);
        in_valid = 0; s_in = 0; out_ready = 0;
        rst_n = 1'b0;
        #1;
        mq.delete(); m_ovf = 0; m_ill = 0;
        check("arst_valid", out_valid, 0);
        check("arst_level", level, 0);
        check("arst_byte", out_byte, 8'h00);
        check("arst_flags", {overflow, illegal}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 8'h04, 0, 0, 0);
        check("post_rst_byte", out_byte, 8'h2B);
        check("post_rst_level", level, 1);
        drive(0, 8'h00, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit         v, n, r, c;
            int         mode;
            v    = $urandom_range(0, 3) != 0;
            mode = $urandom_range(0, 9);
            if (mode < 7) st = 8'(1) << $urandom_range(0, 7);
            else if (mode == 7) st = 8'h00;
            else st = 8'($urandom);
            n = $urandom_range(0, 7) == 0;
            r = ((i % 300) < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = $urandom_range(0, 15) == 0;
            drive(v, st, n, r, c);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
